// File: rtl/framebuffer_fetch_multi_pkg.sv
// framebuffer_fetch_multi_pkg: shared display constants, fetch state encoding and RAM address packing.
package framebuffer_fetch_multi_pkg;

    localparam int RGB565_R_LSB  = 11;
    localparam int RGB565_R_BITS = 5;
    localparam int RGB565_G_LSB  = 5;
    localparam int RGB565_G_BITS = 6;
    localparam int RGB565_B_LSB  = 0;
    localparam int RGB565_B_BITS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } fetch_state_e;

    // {channel, row, column}; the framebuffer write port uses the same layout
    function automatic logic [31:0] pack_ram_address(input logic [31:0] channel,
                                                     input logic [31:0] row,
                                                     input logic [31:0] column,
                                                     input int          row_bits,
                                                     input int          column_bits);
        return (channel << (row_bits + column_bits)) | (row << column_bits) | column;
    endfunction

endpackage

// File: rtl/framebuffer_fetch_multi_capture_shift.sv
// fetch_capture_shift: carries {valid, channel} from address issue to the cycle its RAM data is valid.
module fetch_capture_shift #(
    parameter int DEPTH        = 2,
    parameter int CHANNEL_BITS = 1
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [CHANNEL_BITS-1:0] in_chan,
    output logic                    out_valid,
    output logic [CHANNEL_BITS-1:0] out_chan
);

    logic [CHANNEL_BITS:0] sr_q [DEPTH];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= {in_valid, in_chan};
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign {out_valid, out_chan} = sr_q[DEPTH-1];

endmodule

// File: rtl/framebuffer_fetch_multi.sv
// framebuffer_fetch_multi: fetches one pixel word per channel from latency-L RAM and
// presents the full set atomically with a valid pulse.
module framebuffer_fetch_multi
    import framebuffer_fetch_multi_pkg::*;
#(
    parameter int COLUMN_BITS    = 6,
    parameter int ROW_BITS       = 4,
    parameter int CHANNEL_BITS   = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int RAM_LATENCY    = 2,
    parameter bit MIRROR_COLUMNS = 1
) (
    input  logic                                         clk_in,
    input  logic                                         reset,
    input  logic [COLUMN_BITS-1:0]                       column_address,
    input  logic [ROW_BITS-1:0]                          row_address,
    input  logic                                         pixel_load_start,
    input  logic [DATA_WIDTH-1:0]                        ram_data_in,
    output logic [CHANNEL_BITS+ROW_BITS+COLUMN_BITS-1:0] ram_address,
    output logic                                         ram_clk_enable,
    output logic                                         ram_reset,
    output logic [(1<<CHANNEL_BITS)*DATA_WIDTH-1:0]      pixel_data,
    output logic                                         pixel_valid,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int CHANNELS = 1 << CHANNEL_BITS;
    localparam int AW       = CHANNEL_BITS + ROW_BITS + COLUMN_BITS;
    localparam int CW       = $clog2(CHANNELS + RAM_LATENCY + 1);
    localparam int PW       = CHANNELS * DATA_WIDTH;

    fetch_state_e            state_q, state_d;
    logic [ROW_BITS-1:0]     row_q, row_d;
    logic [COLUMN_BITS-1:0]  col_q, col_d, col_in;
    logic [CHANNEL_BITS:0]   issue_q, issue_d, issue_next;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [PW-1:0]           stage_q, stage_d, pix_q, pix_d;
    logic                    busy_q, busy_d, valid_q, valid_d, overrun_q, overrun_d;
    logic                    fetching, accept, last, issuing, more;
    logic                    cap_valid;
    logic [CHANNEL_BITS-1:0] cap_chan;

    assign col_in     = MIRROR_COLUMNS ? ~column_address : column_address;
    assign fetching   = state_q == FETCH;
    assign accept     = pixel_load_start && !fetching;
    assign last       = fetching && cyc_q == CW'(CHANNELS + RAM_LATENCY - 1);
    assign issue_next = issue_q + 1'b1;
    assign issuing    = fetching && issue_q < (CHANNEL_BITS+1)'(CHANNELS);
    assign more       = fetching && issue_next < (CHANNEL_BITS+1)'(CHANNELS);

    fetch_capture_shift #(
        .DEPTH       (RAM_LATENCY),
        .CHANNEL_BITS(CHANNEL_BITS)
    ) u_capture_shift (
        .clk_in   (clk_in),
        .reset    (reset),
        .in_valid (issuing),
        .in_chan  (issue_q[CHANNEL_BITS-1:0]),
        .out_valid(cap_valid),
        .out_chan (cap_chan)
    );

    always_comb begin
        state_d   = accept ? FETCH : last ? COMMIT : state_q == COMMIT ? IDLE : state_q;
        row_d     = accept ? row_address : row_q;
        col_d     = accept ? col_in : col_q;
        issue_d   = accept ? '0 : issuing ? issue_next : issue_q;
        cyc_d     = accept ? '0 : fetching ? cyc_q + 1'b1 : cyc_q;
        addr_d    = accept ? AW'(pack_ram_address(32'd0, 32'(row_address), 32'(col_in), ROW_BITS, COLUMN_BITS))
                  : more   ? AW'(pack_ram_address(32'(issue_next), 32'(row_q), 32'(col_q), ROW_BITS, COLUMN_BITS))
                  : addr_q;
        stage_d   = stage_q;
        if (cap_valid) stage_d[cap_chan*DATA_WIDTH +: DATA_WIDTH] = ram_data_in;
        // last capture lands in the same edge as the commit, so commit the merged set
        pix_d     = last ? stage_d : pix_q;
        valid_d   = last;
        busy_d    = state_d == FETCH;
        overrun_d = overrun_q | (pixel_load_start && fetching);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            issue_q   <= '0;
            cyc_q     <= '0;
            addr_q    <= '0;
            stage_q   <= '0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            issue_q   <= issue_d;
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            stage_q   <= stage_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign ram_address    = addr_q;
    assign ram_clk_enable = busy_q;
    assign ram_reset      = reset;
    assign pixel_data     = pix_q;
    assign pixel_valid    = valid_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;

endmodule

// File: doc/framebuffer_fetch_multi.md
# framebuffer_fetch_multi

Parametrised framebuffer read engine that sits between the scan controller and the framebuffer block RAM. On each pixel-load request it fetches one pixel word per display channel (sub-panel) for the given row/column from a RAM with configurable read latency. It presents all channel words atomically on a wide output bus. It generalises the fixed two-half, two-cycle fetch to N channels, any RAM latency, and optional column mirroring, and adds valid/busy/overrun signalling.

## Interface
- COLUMN_BITS, 6: column address width.
- ROW_BITS, 4: row address width.
- CHANNEL_BITS, 1: log2 of channel count; CHANNELS = 2^CHANNEL_BITS.
- DATA_WIDTH, 16: pixel word width (RGB565 default).
- RAM_LATENCY, 2: cycles from ram_address to valid ram_data_in; legal range 1..7.
- MIRROR_COLUMNS, 1: when 1, the column field of ram_address is bitwise-inverted.

- clk_in  in  1  clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- column_address  in  COLUMN_BITS  pixel column; sampled on accept.
- row_address  in  ROW_BITS  scan row; sampled on accept.
- pixel_load_start  in  1  fetch request, single-cycle pulse or level.
- ram_data_in  in  DATA_WIDTH  RAM read data.
- ram_address  out  CHANNEL_BITS+ROW_BITS+COLUMN_BITS  {channel, row, column'}.
- ram_clk_enable  out  1  RAM clock enable.
- ram_reset  out  1  equals reset, combinational.
- pixel_data  out  CHANNELS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- pixel_valid  out  1  one-cycle pulse when pixel_data updates.
- busy  out  1  fetch in progress.
- overrun  out  1  sticky; request arrived while busy.

## Operation
- States: IDLE, FETCH, COMMIT.
- IDLE: pixel_load_start high at a rising edge accepts the request. Latch row, column (inverted if MIRROR_COLUMNS), clear issue and capture counters, go to FETCH.
- FETCH, issue side: in fetch cycle i (i = 0..CHANNELS-1), ram_address = {i, row, column'}. After the last channel, hold the last address.
- FETCH, capture side: data for channel k is valid in fetch cycle k+RAM_LATENCY. Store it into a staging register at the rising edge ending that cycle. After the last capture, go to COMMIT.
- COMMIT lasts one cycle. Copy the staging registers into pixel_data in one edge, raise pixel_valid, return to IDLE. pixel_data never shows a partially updated set.
- pixel_load_start while busy: ignored, and overrun is set. Only reset clears overrun.
- Row/column changes during FETCH have no effect.
- Reset, including mid-fetch: abort and return to IDLE. ram_address = 0, ram_clk_enable = 0, pixel_data = 0, pixel_valid = 0, busy = 0, overrun = 0, staging registers = 0. No commit happens for the aborted fetch.

## Timing
- Request sampled at edge E0.
- FETCH occupies cycles 1..CHANNELS+RAM_LATENCY.
- busy and ram_clk_enable are high exactly during the FETCH cycles. Both are registered outputs.
- Address for channel k is presented in cycle 1+k.
- pixel_valid and the new pixel_data appear in cycle CHANNELS+RAM_LATENCY+1. busy is already low in that cycle.
- A new request can be accepted in the pixel_valid cycle. Throughput: one load per CHANNELS+RAM_LATENCY+1 cycles.
- Default parameters: request at E0, addresses in cycles 1–2, captures at the ends of cycles 3–4, pixel_valid in cycle 5.
- Counter widths: the issue counter needs CHANNEL_BITS+1 bits; the cycle counter needs clog2(CHANNELS+RAM_LATENCY+1) bits. No counter wraps within a fetch.

## Structure
- Shared display package holds:
  - the RGB565 field constants;
  - the state encoding localparams (IDLE/FETCH/COMMIT);
  - the ram_address field-packing helper, shared with the framebuffer write port.
- One sub-module, fetch_capture_shift: a RAM_LATENCY-deep shift register carrying channel index and valid flag from issue to capture. It makes capture timing independent of the FSM.

## Test plan
- Defaults with a RAM model of latency 2. Request row 5, column 0x0A -> addresses 0x175 then 0x575. pixel_valid in cycle 5. pixel_data = {RAM[0x575], RAM[0x175]}.
- CHANNEL_BITS=2, RAM_LATENCY=3, MIRROR_COLUMNS=0. Request row 0, column 3 -> four addresses differing only in the top 2 bits. busy for 7 cycles. pixel_valid in cycle 8.
- Back-to-back: second request in the pixel_valid cycle -> accepted. Its addresses start the next cycle, and overrun stays 0.
- Request during FETCH cycle 2 -> ignored, overrun=1. First result is unchanged and no second pixel_valid occurs.
- Reset asserted in FETCH cycle 3 -> all outputs 0 immediately. No pixel_valid follows. Next request behaves normally.
- Change row/column inputs every cycle during a fetch -> ram_address still uses the values latched at accept.
